// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port round-robin arbiter with bounded locked bursts for a single-port memory
module mem_port_arbiter #(
   parameter int AW        = 8,
   parameter int DW        = 8,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_a,
   input  logic          lock_a,
   input  logic          we_a,
   input  logic [AW-1:0] addr_a,
   input  logic [DW-1:0] wdata_a,
   output logic          gnt_a,
   output logic          rvalid_a,
   input  logic          req_b,
   input  logic          lock_b,
   input  logic          we_b,
   input  logic [AW-1:0] addr_b,
   input  logic [DW-1:0] wdata_b,
   output logic          gnt_b,
   output logic          rvalid_b,
   output logic [DW-1:0] rdata,
   input  logic          mem_ready,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] OWN_A = 2'd1;
   localparam logic [1:0] OWN_B = 2'd2;

   localparam int            CW      = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

   logic [1:0]    state;
   logic          prio;            // 0: A wins a tie, 1: B wins a tie
   logic [CW-1:0] burst_cnt;
   logic          rvalid_a_q, rvalid_b_q;
   logic          own_a, own_b, win_a, win_b;
   logic [CW-1:0] next_cnt_a, next_cnt_b;

   assign own_a = (state == OWN_A) && lock_a;
   assign own_b = (state == OWN_B) && lock_b;

   always_comb begin
      win_a = req_a && (own_a || (!own_b && (!req_b || !prio)));
      win_b = req_b && (own_b || (!own_a && (!req_a || prio)));
   end

   assign gnt_a = !rst && mem_ready && win_a;
   assign gnt_b = !rst && mem_ready && win_b;

   assign mem_en    = gnt_a || gnt_b;
   assign mem_we    = gnt_a ? we_a : (gnt_b ? we_b : 1'b0);
   assign mem_addr  = gnt_a ? addr_a : (gnt_b ? addr_b : '0);
   assign mem_wdata = gnt_a ? wdata_a : (gnt_b ? wdata_b : '0);

   // A return pending when reset arrives is dropped in the reset cycle itself
   assign rvalid_a = rvalid_a_q && !rst;
   assign rvalid_b = rvalid_b_q && !rst;
   assign rdata    = mem_rdata;

   assign next_cnt_a = (state == OWN_A) ? burst_cnt + CW'(1) : CW'(1);
   assign next_cnt_b = (state == OWN_B) ? burst_cnt + CW'(1) : CW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         prio       <= 1'b0;
         burst_cnt  <= '0;
         rvalid_a_q <= 1'b0;
         rvalid_b_q <= 1'b0;
      end else begin
         rvalid_a_q <= gnt_a && !we_a;
         rvalid_b_q <= gnt_b && !we_b;
         if (gnt_a) begin
            prio <= 1'b1;
            if (lock_a && (next_cnt_a < MAX_CNT)) begin
               state     <= OWN_A;
               burst_cnt <= next_cnt_a;
            end else begin
               state     <= IDLE;
               burst_cnt <= '0;
            end
         end else if (gnt_b) begin
            prio <= 1'b0;
            if (lock_b && (next_cnt_b < MAX_CNT)) begin
               state     <= OWN_B;
               burst_cnt <= next_cnt_b;
            end else begin
               state     <= IDLE;
               burst_cnt <= '0;
            end
         end else if (mem_ready && ((state == OWN_A && !lock_a) ||
                                    (state == OWN_B && !lock_b))) begin
            state     <= IDLE;
            burst_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter: directed scenarios plus random traffic
module tb_mem_port_arbiter;

   localparam int MAXB = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_a, lock_a, we_a, req_b, lock_b, we_b, mem_ready;
   logic [7:0] addr_a, wdata_a, addr_b, wdata_b, mem_rdata;
   logic       gnt_a, gnt_b, rvalid_a, rvalid_b, mem_en, mem_we;
   logic [7:0] rdata, mem_addr, mem_wdata;

   mem_port_arbiter #(.AW(8), .DW(8), .MAX_BURST(MAXB)) dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .lock_a(lock_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
      .gnt_a(gnt_a), .rvalid_a(rvalid_a),
      .req_b(req_b), .lock_b(lock_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
      .gnt_b(gnt_b), .rvalid_b(rvalid_b),
      .rdata(rdata), .mem_ready(mem_ready), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       ga, gb, en, we, rva, rvb;
      logic [7:0] addr, wdata, rdata;
   } exp_t;

   exp_t expq[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model: who owns the memory, how many locked grants it has had, who wins a tie
   int   m_owner = 0;   // 0 nobody, 1 A, 2 B
   int   m_run   = 0;
   bit   m_tie_b = 0;
   bit   m_pend_a = 0, m_pend_b = 0;

   logic [15:0] glog = '0;
   logic        last_we;
   logic [7:0]  last_addr, last_wdata;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic model_grant(input bit x_is_a, input bit lock);
      int n;
      m_tie_b = x_is_a;
      n = (m_owner == (x_is_a ? 1 : 2)) ? m_run + 1 : 1;
      if (lock && n < MAXB) begin
         m_owner = x_is_a ? 1 : 2;
         m_run   = n;
      end else begin
         m_owner = 0;
         m_run   = 0;
      end
   endtask

   task automatic drive(input bit r, input bit rdy,
                        input bit ra, input bit la, input bit wa, input logic [7:0] aa, input logic [7:0] da,
                        input bit rb, input bit lb, input bit wb, input logic [7:0] ab, input logic [7:0] db);
      exp_t e;
      bit   ga, gb;
      logic [7:0] rd;
      rd = 8'($urandom);
      rst = r; mem_ready = rdy; mem_rdata = rd;
      req_a = ra; lock_a = la; we_a = wa; addr_a = aa; wdata_a = da;
      req_b = rb; lock_b = lb; we_b = wb; addr_b = ab; wdata_b = db;
      ga = 0; gb = 0;
      if (!r && rdy) begin
         if (m_owner == 1 && la)      ga = ra;
         else if (m_owner == 2 && lb) gb = rb;
         else if (ra && rb)           begin ga = !m_tie_b; gb = m_tie_b; end
         else                         begin ga = ra; gb = rb; end
      end
      e.ga = ga; e.gb = gb; e.en = ga | gb;
      e.we    = ga ? wa : (gb ? wb : 1'b0);
      e.addr  = ga ? aa : (gb ? ab : 8'h00);
      e.wdata = ga ? da : (gb ? db : 8'h00);
      e.rva = m_pend_a && !r; e.rvb = m_pend_b && !r; e.rdata = rd;
      expq.push_back(e);
      if (r) begin
         m_owner = 0; m_run = 0; m_tie_b = 0;
      end else if (ga) model_grant(1'b1, la);
      else if (gb)     model_grant(1'b0, lb);
      else if (rdy && ((m_owner == 1 && !la) || (m_owner == 2 && !lb))) begin
         m_owner = 0; m_run = 0;
      end
      m_pend_a = ga && !wa;
      m_pend_b = gb && !wb;
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input bit r);
      drive(r, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         glog = {glog[13:0], gnt_a, gnt_b};
         if (mem_en) begin
            last_we = mem_we; last_addr = mem_addr; last_wdata = mem_wdata;
         end
         if (expq.size() > 0) begin
            e = expq.pop_front();
            tests++;
            if (gnt_a !== e.ga || gnt_b !== e.gb || mem_en !== e.en || mem_we !== e.we ||
                mem_addr !== e.addr || mem_wdata !== e.wdata || rvalid_a !== e.rva ||
                rvalid_b !== e.rvb || ((e.rva || e.rvb) && rdata !== e.rdata)) begin
               fails++;
               $display("FAIL cycle @%0t: got gnt=%b%b en=%b we=%b addr=%h wd=%h rv=%b%b rd=%h expected gnt=%b%b en=%b we=%b addr=%h wd=%h rv=%b%b rd=%h",
                        $time, gnt_a, gnt_b, mem_en, mem_we, mem_addr, mem_wdata, rvalid_a, rvalid_b, rdata,
                        e.ga, e.gb, e.en, e.we, e.addr, e.wdata, e.rva, e.rvb, e.rdata);
            end
         end
      end
   end

   initial begin
      rst = 1; mem_ready = 1; mem_rdata = 0;
      req_a = 0; lock_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
      req_b = 0; lock_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
      @(posedge clk); #1;
      idle(1); idle(1);
      // reset state: no grants, no strobe
      check("reset_gnt", {14'd0, glog[1:0]}, 16'h0000);

      // single read from A, return next cycle
      drive(0, 1, 1, 0, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
      check("t1_addr", {8'h00, last_addr}, 16'h0010);
      idle(0);

      // plain round-robin from reset
      idle(1);
      for (int i = 0; i < 4; i++) drive(0, 1, 1, 0, 0, 8'(i), 8'h00, 1, 0, 0, 8'(8'h80 + i), 8'h00);
      check("t2_rr", {8'h00, glog[7:0]}, 16'b10_01_10_01);
      idle(0);

      // locked burst by B is cut at MAX_BURST, A then wins
      idle(1);
      drive(0, 1, 1, 0, 0, 8'h20, 8'h00, 0, 0, 0, 8'h00, 8'h00);
      for (int i = 0; i < 5; i++) drive(0, 1, 1, 0, 0, 8'h21, 8'h00, 1, 1, 0, 8'(8'h40 + i), 8'h00);
      check("t3_burst", {6'd0, glog[9:0]}, 16'b01_01_01_01_10);

      // stalled memory: no grants, then the prio port (B) goes first
      for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, 8'h30, 8'h00, 1, 0, 0, 8'h31, 8'h00);
      drive(0, 1, 1, 0, 0, 8'h30, 8'h00, 1, 0, 0, 8'h31, 8'h00);
      check("t4_stall", {8'h00, glog[7:0]}, 16'b00_00_00_01);

      // reset right after a B read drops the return; A wins afterwards
      drive(0, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h55, 8'h00);
      drive(1, 1, 1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00);
      drive(0, 1, 1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00);
      check("t5_rst", {10'd0, glog[5:0]}, 16'b01_00_10);

      // write by A
      idle(0);
      drive(0, 1, 1, 0, 1, 8'h03, 8'h5A, 0, 0, 0, 8'h00, 8'h00);
      check("t6_write", {7'd0, last_we, last_addr}, 16'h0103);
      check("t6_wdata", {8'h00, last_wdata}, 16'h005A);
      idle(0);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 59) == 0, $urandom_range(0, 4) != 0,
               $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5, $urandom_range(0, 9) < 3,
               8'($urandom), 8'($urandom),
               $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5, $urandom_range(0, 9) < 3,
               8'($urandom), 8'($urandom));
      end
      idle(0);
      check("queue_drained", 16'(expq.size()), 16'h0000);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
